modn_counter: RTL and testbench



---
 rtl/modn_counter.sv | 153 +++++++++++++++
 tb/tb_modn_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/modn_counter.sv
// modn_counter: modulo-MODULUS time-digit counter for the clock datapath.
// Advances on a one-cycle tick strobe. It also provides up/down manual adjust
// with press-and-hold auto-repeat, a synchronous load, a one-cycle carry pulse
// on wrap, and BCD digit outputs for the display driver.
//
// Ports:
//   clk        system clock, rising edge
//   clear_n    synchronous active-low reset
//   tick       count strobe, one cycle wide
//   keep       freeze: blocks tick and adjust steps (load still applies)
//   adjust     adjust mode: ticks ignored, button steps accepted
//   adj_btn    adjust button level (debounced, synchronised)
//   adj_down   adjust direction, 1 = decrement
//   load       synchronous load strobe
//   load_value value to load (out-of-range values load 0)
//   value      current count, registered
//   carry      registered one-cycle wrap pulse, aligned with value reading 0
//   zero       value == 0
//   tens/ones  BCD digits of value
module modn_counter #(
  parameter int unsigned MODULUS       = 60,
  parameter int unsigned WIDTH         = 6,
  parameter int unsigned HOLD_CYCLES   = 500,
  parameter int unsigned REPEAT_CYCLES = 100
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             tick,
  input  logic             keep,
  input  logic             adjust,
  input  logic             adj_btn,
  input  logic             adj_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             zero,
  output logic [3:0]       tens,
  output logic [3:0]       ones
);

  localparam int unsigned MAX_CYC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TW-1:0]    HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]    REP_LAST  = TW'(REPEAT_CYCLES - 1);
  localparam logic [WIDTH-1:0] LAST      = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [TW-1:0]   timer;
  logic [TW-1:0]   timer_next;
  logic            btn_hist;
  logic            step;
  logic [WIDTH-1:0] inc_value;
  logic [WIDTH-1:0] dec_value;
  logic            load_ok;

  assign inc_value = (value == LAST) ? '0 : value + 1'b1;
  assign dec_value = (value == '0) ? LAST : value - 1'b1;
  assign load_ok   = ({1'b0, load_value} < MOD_EXT);

  // Adjust sequencer next-state and step decision. Leaving adjust mode
  // parks the sequencer in IDLE with a cleared timer.
  always_comb begin
    state_next = state;
    timer_next = timer;
    step       = 1'b0;
    if (!adjust) begin
      state_next = IDLE;
      timer_next = '0;
    end else begin
      case (state)
        IDLE: begin
          if (adj_btn && !btn_hist) begin
            step       = 1'b1;
            timer_next = '0;
            state_next = HOLD;
          end
        end
        HOLD: begin
          if (!adj_btn) begin
            state_next = IDLE;
            timer_next = '0;
          end else if (timer == HOLD_LAST) begin
            step       = 1'b1;
            timer_next = '0;
            state_next = REPEAT;
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        REPEAT: begin
          if (!adj_btn) begin
            state_next = IDLE;
            timer_next = '0;
          end else if (timer == REP_LAST) begin
            step       = 1'b1;
            timer_next = '0;
          end else begin
            timer_next = timer + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          timer_next = '0;
        end
      endcase
    end
  end

  // The sequencer always advances; keep/load only suppress the value change.
  // btn_hist resets to 1 so a button held through reset must be re-pressed.
  always_ff @(posedge clk) begin
    if (!clear_n) begin
      value    <= '0;
      carry    <= 1'b0;
      state    <= IDLE;
      timer    <= '0;
      btn_hist <= 1'b1;
    end else begin
      state    <= state_next;
      timer    <= timer_next;
      btn_hist <= adj_btn;
      carry    <= 1'b0;
      if (load) begin
        value <= load_ok ? load_value : '0;
      end else if (step && !keep) begin
        value <= adj_down ? dec_value : inc_value;
      end else if (tick && !adjust && !keep) begin
        value <= inc_value;
        carry <= (value == LAST);
      end
    end
  end

  logic [31:0] value_ext;

  always_comb begin
    value_ext = 32'(value);
    zero      = (value == '0);
    tens      = 4'(value_ext / 32'd10);
    ones      = 4'(value_ext % 32'd10);
  end

endmodule

// File: tb/tb_modn_counter.sv
// Scoreboard bench for modn_counter: directed stimulus pushes hand-computed
// expected post-edge states into a queue; a monitor on the falling edge pops
// and compares them against the DUT outputs.
module tb_modn_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear_n = 1'b0;
  // DUT A: MODULUS 60, WIDTH 7 (so an out-of-range 75 can be loaded)
  logic       a_tick = 0, a_keep = 0, a_adjust = 0, a_btn = 0, a_down = 0, a_load = 0;
  logic [6:0] a_lv = '0;
  logic [6:0] a_value;
  logic       a_carry, a_zero;
  logic [3:0] a_tens, a_ones;
  // DUT B: MODULUS 24, WIDTH 5
  logic       b_tick = 0, b_keep = 0, b_adjust = 0, b_btn = 0, b_down = 0, b_load = 0;
  logic [4:0] b_lv = '0;
  logic [4:0] b_value;
  logic       b_carry, b_zero;
  logic [3:0] b_tens, b_ones;

  modn_counter #(.MODULUS(60), .WIDTH(7), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) dut_a (
    .clk(clk), .clear_n(clear_n), .tick(a_tick), .keep(a_keep), .adjust(a_adjust),
    .adj_btn(a_btn), .adj_down(a_down), .load(a_load), .load_value(a_lv),
    .value(a_value), .carry(a_carry), .zero(a_zero), .tens(a_tens), .ones(a_ones)
  );

  modn_counter #(.MODULUS(24), .WIDTH(5), .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) dut_b (
    .clk(clk), .clear_n(clear_n), .tick(b_tick), .keep(b_keep), .adjust(b_adjust),
    .adj_btn(b_btn), .adj_down(b_down), .load(b_load), .load_value(b_lv),
    .value(b_value), .carry(b_carry), .zero(b_zero), .tens(b_tens), .ones(b_ones)
  );

  typedef struct {
    string name;
    bit    sel;
    int    v;
    int    c;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;

  task automatic check(input string nm, input string field, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, field, act, exp);
    end
  endtask

  task automatic push(input string nm, input bit sel, input int v, input int c);
    exp_t e;
    e.name = nm; e.sel = sel; e.v = v; e.c = c;
    q.push_back(e);
  endtask

  // One active edge, then settle away from it before changing inputs.
  task automatic tk();
    @(posedge clk);
    #1;
  endtask

  // Monitor: DUT outputs are presented every cycle; compare all pending entries.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      int   v, c, z, t, o;
      e = q.pop_front();
      if (e.sel) begin
        v = int'(b_value); c = int'(b_carry); z = int'(b_zero); t = int'(b_tens); o = int'(b_ones);
      end else begin
        v = int'(a_value); c = int'(a_carry); z = int'(a_zero); t = int'(a_tens); o = int'(a_ones);
      end
      check(e.name, "value", v, e.v);
      check(e.name, "carry", c, e.c);
      check(e.name, "zero",  z, (e.v == 0) ? 1 : 0);
      check(e.name, "tens",  t, e.v / 10);
      check(e.name, "ones",  o, e.v % 10);
    end
  end

  int rep_exp [9] = '{11, 11, 11, 11, 12, 12, 13, 13, 14};

  initial begin
    // Reset held two cycles with tick asserted
    clear_n = 1'b0; a_tick = 1; b_tick = 1;
    tk(); tk();
    push("reset_a", 0, 0, 0);
    push("reset_b", 1, 0, 0);
    clear_n = 1'b1; a_tick = 0; b_tick = 0;

    // Count to 59, then wrap
    a_tick = 1;
    for (int i = 1; i <= 59; i++) begin
      tk();
      if (i == 1) push("count1", 0, 1, 0);
      if (i == 35) push("count35", 0, 35, 0);
    end
    push("count59", 0, 59, 0);
    tk(); push("wrap", 0, 0, 1);
    a_tick = 0;
    tk(); push("carry_one_cycle", 0, 0, 0);

    // Ticks discarded under keep and adjust
    a_keep = 1; a_tick = 1;
    tk(); push("tick_keep", 0, 0, 0);
    a_keep = 0; a_adjust = 1;
    tk(); push("tick_adjust", 0, 0, 0);
    a_tick = 0;

    // Load 10, then hold the button 9 cycles: steps at edges 0,4,6,8
    a_load = 1; a_lv = 7'd10;
    tk(); push("load10", 0, 10, 0);
    a_load = 0;
    a_btn = 1;
    for (int i = 0; i < 9; i++) begin
      tk(); push($sformatf("repeat_e%0d", i), 0, rep_exp[i], 0);
    end
    a_btn = 0;
    tk(); push("release", 0, 14, 0);
    a_btn = 1;
    tk(); push("repress", 0, 15, 0);
    a_btn = 0;
    tk(); push("repress_rel", 0, 15, 0);

    // Down-wrap from 0, then a press under keep
    a_load = 1; a_lv = 7'd0;
    tk(); push("load0", 0, 0, 0);
    a_load = 0; a_down = 1; a_btn = 1;
    tk(); push("down_wrap", 0, 59, 0);
    a_btn = 0;
    tk();
    a_keep = 1; a_btn = 1;
    tk(); push("keep_step", 0, 59, 0);
    a_btn = 0; a_keep = 0;
    tk();

    // Out-of-range load, then load beats a same-cycle tick
    a_load = 1; a_lv = 7'd75;
    tk(); push("load75", 0, 0, 0);
    a_adjust = 0; a_down = 0; a_lv = 7'd42; a_tick = 1;
    tk(); push("load42_tick", 0, 42, 0);
    a_load = 0; a_tick = 0;

    // Reset during REPEAT with the button held
    a_adjust = 1; a_btn = 1;
    tk(); push("mid_e0", 0, 43, 0);
    tk(); tk(); tk();
    tk(); push("mid_e4", 0, 44, 0);
    tk();
    clear_n = 1'b0;
    tk(); push("reset_mid", 0, 0, 0);
    clear_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tk(); push("held_no_step", 0, 0, 0);
    end
    a_btn = 0;
    tk(); push("released", 0, 0, 0);
    a_btn = 1;
    tk(); push("press_after_reset", 0, 1, 0);
    a_btn = 0; a_adjust = 0;
    tk();

    // MODULUS 24: load 23, tick wraps with carry
    b_load = 1; b_lv = 5'd23;
    tk(); push("b_load23", 1, 23, 0);
    b_load = 0; b_tick = 1;
    tk(); push("b_wrap", 1, 0, 1);
    b_tick = 0;
    tk(); push("b_after_wrap", 1, 0, 0);
    b_load = 1; b_lv = 5'd24;
    tk(); push("b_load24", 1, 0, 0);
    b_lv = 5'd17;
    tk(); push("b_load17", 1, 17, 0);
    b_load = 0;

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    compared++;
    if (q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
